// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester ports, the ALU steering/return path and the
// buffered result port of alu_arbiter.
//
// Handshake (all three ports): a beat transfers on a rising clock edge when
// valid and ready are both high in that cycle. The producer holds valid and
// payload stable until ready; ready may depend on valid, never the reverse.
//
// Parameters: XLEN (datapath width), UOP_W (packed uop width), TAG_W (tag width)
// Modports:
//   slave  - the arbiter side (consumes requests, drives ALU inputs and result)
//   master - the environment side (requesters, ALU, result consumer)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int UOP_W = 96,
  parameter int TAG_W = 4
);
  // requester 0
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [XLEN-1:0]  req0_rs1_i;
  logic [XLEN-1:0]  req0_rs2_i;
  logic [UOP_W-1:0] req0_uop_i;
  logic [TAG_W-1:0] req0_tag_i;
  // requester 1
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [XLEN-1:0]  req1_rs1_i;
  logic [XLEN-1:0]  req1_rs2_i;
  logic [UOP_W-1:0] req1_uop_i;
  logic [TAG_W-1:0] req1_tag_i;
  // ALU steering and combinational return
  logic [XLEN-1:0]  alu_rs1_o;
  logic [XLEN-1:0]  alu_rs2_o;
  logic [UOP_W-1:0] alu_uop_o;
  logic [XLEN-1:0]  alu_res_i;
  logic             alu_jump_i;
  // buffered result
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_res_o;
  logic             out_jump_o;
  logic             out_src_o;
  logic [TAG_W-1:0] out_tag_o;

  modport slave (
    input  req0_valid_i, req0_rs1_i, req0_rs2_i, req0_uop_i, req0_tag_i,
    output req0_ready_o,
    input  req1_valid_i, req1_rs1_i, req1_rs2_i, req1_uop_i, req1_tag_i,
    output req1_ready_o,
    output alu_rs1_o, alu_rs2_o, alu_uop_o,
    input  alu_res_i, alu_jump_i,
    output out_valid_o, out_res_o, out_jump_o, out_src_o, out_tag_o,
    input  out_ready_i
  );

  modport master (
    output req0_valid_i, req0_rs1_i, req0_rs2_i, req0_uop_i, req0_tag_i,
    input  req0_ready_o,
    output req1_valid_i, req1_rs1_i, req1_rs2_i, req1_uop_i, req1_tag_i,
    input  req1_ready_o,
    input  alu_rs1_o, alu_rs2_o, alu_uop_o,
    output alu_res_i, alu_jump_i,
    input  out_valid_o, out_res_o, out_jump_o, out_src_o, out_tag_o,
    output out_ready_i
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one single-cycle integer ALU between the main EXU issue path (port 0)
// and an auxiliary path (port 1). Round-robin arbitration picks a winner, its
// operands/uop are steered to the ALU, and the ALU result plus jump flag are
// captured in a one-entry output register (1-cycle latency, 1 op/cycle).
//
// Ports:
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   flush_i         - synchronous flush of the result register and RR pointer
//   bus             - alu_arbiter_if.slave (requesters, ALU path, result port)
//   dbg_rr_ptr_o    - current round-robin state (0 = port 0 preferred)
//   perf_grant0_o, perf_grant1_o, perf_stall_o
//                   - 32-bit saturating counters, present only when the macro
//                     ALU_ARB_PERF_EN is defined
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int UOP_W = 96,
  parameter int TAG_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  alu_arbiter_if.slave bus,
  output logic         dbg_rr_ptr_o
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]  perf_grant0_o,
  output logic [31:0]  perf_grant1_o,
  output logic [31:0]  perf_stall_o
`endif
);

  typedef enum logic {
    RR_P0 = 1'b0,
    RR_P1 = 1'b1
  } rr_state_t;

  rr_state_t rr_q, rr_d;

  logic             can_accept;
  logic             accept_en;
  logic             grant0, grant1;
  logic             xfer0, xfer1, xfer;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_res_q;
  logic             out_jump_q;
  logic             out_src_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [XLEN-1:0]  rs1_sel, rs2_sel;
  logic [UOP_W-1:0] uop_sel;
  logic [TAG_W-1:0] tag_sel;

  // Arbitration. Grants depend only on the valids and the RR state, so a
  // ready never feeds back on itself.
  always_comb begin
    can_accept = ~out_valid_q | bus.out_ready_i;
    accept_en  = can_accept & ~flush_i;
    grant0     = bus.req0_valid_i & (~bus.req1_valid_i | (rr_q == RR_P0));
    grant1     = bus.req1_valid_i & (~bus.req0_valid_i | (rr_q == RR_P1));
    xfer0      = grant0 & accept_en;
    xfer1      = grant1 & accept_en;
    xfer       = xfer0 | xfer1;
  end

  // Operand steering: port 1 only when it is granted; otherwise port 0 so the
  // ALU inputs are always driven from a real port.
  always_comb begin
    rs1_sel = bus.req0_rs1_i;
    rs2_sel = bus.req0_rs2_i;
    uop_sel = bus.req0_uop_i;
    tag_sel = bus.req0_tag_i;
    if (grant1) begin
      rs1_sel = bus.req1_rs1_i;
      rs2_sel = bus.req1_rs2_i;
      uop_sel = bus.req1_uop_i;
      tag_sel = bus.req1_tag_i;
    end
  end

  // RR next state: after any transfer, prefer the port that did not win.
  always_comb begin
    rr_d = rr_q;
    if (flush_i) begin
      rr_d = RR_P0;
    end else if (xfer) begin
      rr_d = xfer1 ? RR_P0 : RR_P1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q <= RR_P0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Output register. A pop and a push in the same cycle keep valid high and
  // load the new data, so back-to-back results carry no bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_jump_q  <= 1'b0;
      out_src_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_res_q   <= bus.alu_res_i;
      out_jump_q  <= bus.alu_jump_i;
      out_src_q   <= xfer1;
      out_tag_q   <= tag_sel;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready_o = xfer0;
  assign bus.req1_ready_o = xfer1;
  assign bus.alu_rs1_o    = rs1_sel;
  assign bus.alu_rs2_o    = rs2_sel;
  assign bus.alu_uop_o    = uop_sel;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_res_o    = out_res_q;
  assign bus.out_jump_o   = out_jump_q;
  assign bus.out_src_o    = out_src_q;
  assign bus.out_tag_o    = out_tag_q;
  assign dbg_rr_ptr_o     = rr_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant0_cnt_q, grant1_cnt_q, stall_cnt_q;
  logic        stall;

  // A stall is any cycle with a pending request that did not transfer.
  assign stall = (bus.req0_valid_i | bus.req1_valid_i) & ~xfer;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (xfer0 && (grant0_cnt_q != '1)) grant0_cnt_q <= grant0_cnt_q + 32'd1;
      if (xfer1 && (grant1_cnt_q != '1)) grant1_cnt_q <= grant1_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_grant0_o = grant0_cnt_q;
  assign perf_grant1_o = grant1_cnt_q;
  assign perf_stall_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small ALU model answers the steered
// operands; each accepted request pushes its hand-computed result into
// exp_q, and a monitor pops/compares on every consumed output beat.
// uop encoding used here: uop[3:0] = opcode, uop[63:32] = immediate.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int XLEN  = 32;
  localparam int UOP_W = 96;
  localparam int TAG_W = 4;
  localparam int EXP_W = XLEN + 2 + TAG_W;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;

  // ---------------- clock / reset ----------------
  logic clk_i;
  logic rst_n_i;
  logic flush_i;
  logic dbg_rr_ptr_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_arbiter_if #(.XLEN(XLEN), .UOP_W(UOP_W), .TAG_W(TAG_W)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0_o, perf_grant1_o, perf_stall_o;
`endif

  alu_arbiter #(.XLEN(XLEN), .UOP_W(UOP_W), .TAG_W(TAG_W)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .bus          (bus),
    .dbg_rr_ptr_o (dbg_rr_ptr_o)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0_o(perf_grant0_o),
    .perf_grant1_o(perf_grant1_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  // ---------------- ALU model ----------------
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_imm;
  always_comb begin
    alu_op         = bus.alu_uop_o[3:0];
    alu_imm        = bus.alu_uop_o[63:32];
    bus.alu_res_i  = '0;
    bus.alu_jump_i = 1'b0;
    case (alu_op)
      OP_ADD:  bus.alu_res_i = bus.alu_rs1_o + bus.alu_rs2_o;
      OP_ADDI: bus.alu_res_i = bus.alu_rs1_o + alu_imm;
      OP_SUB:  bus.alu_res_i = bus.alu_rs1_o - bus.alu_rs2_o;
      OP_BEQ: begin
        bus.alu_res_i  = alu_imm;
        bus.alu_jump_i = (bus.alu_rs1_o == bus.alu_rs2_o);
      end
      OP_BNE: begin
        bus.alu_res_i  = alu_imm;
        bus.alu_jump_i = (bus.alu_rs1_o != bus.alu_rs2_o);
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [UOP_W-1:0] mk_uop(input logic [3:0] op, input logic [31:0] imm);
    return {32'h0, imm, 28'h0, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic jump, input logic src,
                          input logic [3:0] tag);
    exp_q.push_back({res, jump, src, tag});
  endtask

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic drive_req(input int port, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [UOP_W-1:0] uop, input logic [3:0] tag);
    if (port == 0) begin
      bus.req0_valid_i = 1'b1;
      bus.req0_rs1_i   = rs1;
      bus.req0_rs2_i   = rs2;
      bus.req0_uop_i   = uop;
      bus.req0_tag_i   = tag;
    end else begin
      bus.req1_valid_i = 1'b1;
      bus.req1_rs1_i   = rs1;
      bus.req1_rs2_i   = rs2;
      bus.req1_uop_i   = uop;
      bus.req1_tag_i   = tag;
    end
  endtask

  task automatic idle(input int port);
    if (port == 0) bus.req0_valid_i = 1'b0;
    else           bus.req1_valid_i = 1'b0;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] mon_exp;
  always @(negedge clk_i) begin
    if (rst_n_i && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected: got tag 0x%0h res 0x%0h expected no output",
                 bus.out_tag_o, bus.out_res_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_result",
              64'({bus.out_res_o, bus.out_jump_o, bus.out_src_o, bus.out_tag_o}),
              64'(mon_exp));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected end of sequence");
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n_i         = 1'b0;
    flush_i         = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.req0_valid_i = 1'b0; bus.req0_rs1_i = '0; bus.req0_rs2_i = '0;
    bus.req0_uop_i   = '0;   bus.req0_tag_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_rs1_i = '0; bus.req1_rs2_i = '0;
    bus.req1_uop_i   = '0;   bus.req1_tag_i = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid_i = 1'($urandom_range(0, 1));
      bus.req1_valid_i = 1'($urandom_range(0, 1));
      bus.req0_rs1_i   = $urandom();
      bus.req1_rs2_i   = $urandom();
      bus.req0_uop_i   = {$urandom(), $urandom(), $urandom()};
      bus.req1_uop_i   = {$urandom(), $urandom(), $urandom()};
      bus.req0_tag_i   = 4'($urandom_range(0, 15));
      bus.req1_tag_i   = 4'($urandom_range(0, 15));
      flush_i          = 1'($urandom_range(0, 1));
      bus.out_ready_i  = 1'($urandom_range(0, 1));
      neg();
      check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      nxt();
    end
    neg();
    check("rst_out_res",  64'(bus.out_res_o),  64'd0);
    check("rst_out_jump", 64'(bus.out_jump_o), 64'd0);
    check("rst_out_src",  64'(bus.out_src_o),  64'd0);
    check("rst_out_tag",  64'(bus.out_tag_o),  64'd0);

    nxt();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    flush_i          = 1'b0;
    bus.out_ready_i  = 1'b1;
    rst_n_i          = 1'b1;
    neg();
    check("post_rst_ready0", 64'(bus.req0_ready_o), 64'd0);
    check("post_rst_ready1", 64'(bus.req1_ready_o), 64'd0);
    check("post_rst_valid",  64'(bus.out_valid_o),  64'd0);
    check("post_rst_rr",     64'(dbg_rr_ptr_o),     64'd0);

    // ADDI on port 0: 5 + 7 = 12.
    nxt();
    drive_req(0, 32'd5, 32'd0, mk_uop(OP_ADDI, 32'd7), 4'd3);
    push_exp(32'd12, 1'b0, 1'b0, 4'd3);
    neg();
    check("addi_ready0", 64'(bus.req0_ready_o), 64'd1);
    check("addi_ready1", 64'(bus.req1_ready_o), 64'd0);
    nxt();
    idle(0);
    neg();
    check("addi_latency_valid", 64'(bus.out_valid_o), 64'd1);
    check("addi_rr",            64'(dbg_rr_ptr_o),     64'd1);

    // Branches on port 1: BEQ taken, BNE not taken.
    nxt();
    drive_req(1, 32'h10, 32'h10, mk_uop(OP_BEQ, 32'h40), 4'd5);
    push_exp(32'h40, 1'b1, 1'b1, 4'd5);
    neg();
    check("beq_ready1", 64'(bus.req1_ready_o), 64'd1);
    nxt();
    drive_req(1, 32'h10, 32'h10, mk_uop(OP_BNE, 32'h80), 4'd6);
    push_exp(32'h80, 1'b0, 1'b1, 4'd6);
    neg();
    check("bne_ready1", 64'(bus.req1_ready_o), 64'd1);

    // Contention: both valid for 4 cycles, grants 0,1,0,1.
    nxt();
    drive_req(0, 32'd1,     32'd2,  mk_uop(OP_ADD, 32'd0), 4'd1);
    drive_req(1, 32'd10,    32'd4,  mk_uop(OP_SUB, 32'd0), 4'd9);
    push_exp(32'd3,        1'b0, 1'b0, 4'd1);
    push_exp(32'd6,        1'b0, 1'b1, 4'd9);
    push_exp(32'h123,      1'b0, 1'b0, 4'd2);
    push_exp(32'hFFFFFFFF, 1'b0, 1'b1, 4'd10);
    neg();
    check("cont0_ready0", 64'(bus.req0_ready_o), 64'd1);
    check("cont0_ready1", 64'(bus.req1_ready_o), 64'd0);
    nxt();
    drive_req(0, 32'h100, 32'h23, mk_uop(OP_ADD, 32'd0), 4'd2);
    neg();
    check("cont1_ready0", 64'(bus.req0_ready_o), 64'd0);
    check("cont1_ready1", 64'(bus.req1_ready_o), 64'd1);
    check("cont1_valid",  64'(bus.out_valid_o),  64'd1);
    nxt();
    drive_req(1, 32'd0, 32'd1, mk_uop(OP_SUB, 32'd0), 4'd10);
    neg();
    check("cont2_ready0", 64'(bus.req0_ready_o), 64'd1);
    check("cont2_ready1", 64'(bus.req1_ready_o), 64'd0);
    check("cont2_valid",  64'(bus.out_valid_o),  64'd1);
    nxt();
    drive_req(0, 32'd7, 32'd7, mk_uop(OP_ADD, 32'd0), 4'd15);  // withdrawn below
    neg();
    check("cont3_ready0", 64'(bus.req0_ready_o), 64'd0);
    check("cont3_ready1", 64'(bus.req1_ready_o), 64'd1);
    check("cont3_valid",  64'(bus.out_valid_o),  64'd1);
    nxt();
    idle(0);
    idle(1);
    neg();
    check("cont_end_valid", 64'(bus.out_valid_o), 64'd1);
    check("cont_end_rr",    64'(dbg_rr_ptr_o),     64'd0);

    // Backpressure: result 0x1234 held for 3 cycles while port 0 waits.
    nxt();
    drive_req(0, 32'h1000, 32'd0, mk_uop(OP_ADDI, 32'h234), 4'd7);
    push_exp(32'h1234, 1'b0, 1'b0, 4'd7);
    neg();
    check("bp_first_ready0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    drive_req(0, 32'hFFFFFFFF, 32'd1, mk_uop(OP_ADD, 32'd0), 4'd8);
    push_exp(32'd0, 1'b0, 1'b0, 4'd8);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      neg();
      check("bp_ready0", 64'(bus.req0_ready_o), 64'd0);
      check("bp_valid",  64'(bus.out_valid_o),  64'd1);
      check("bp_res",    64'(bus.out_res_o),    64'h1234);
      check("bp_tag",    64'(bus.out_tag_o),    64'd7);
    end
    nxt();
    bus.out_ready_i = 1'b1;
    neg();
    check("bp_release_ready0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    idle(0);
    neg();
    check("bp_next_valid", 64'(bus.out_valid_o), 64'd1);

    // Flush with a buffered result and both ports valid.
    nxt();
    drive_req(0, 32'd7, 32'd7, mk_uop(OP_ADD, 32'd0), 4'd11);  // result discarded by flush
    neg();
    check("fl_pre_ready0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    drive_req(0, 32'd20, 32'd0, mk_uop(OP_ADDI, 32'd22), 4'd12);
    drive_req(1, 32'd50, 32'd5, mk_uop(OP_SUB, 32'd0),   4'd13);
    flush_i         = 1'b1;
    bus.out_ready_i = 1'b0;
    neg();
    check("fl_ready0", 64'(bus.req0_ready_o), 64'd0);
    check("fl_ready1", 64'(bus.req1_ready_o), 64'd0);
    check("fl_valid",  64'(bus.out_valid_o),  64'd1);
    check("fl_rr_pre", 64'(dbg_rr_ptr_o),     64'd1);
    nxt();
    flush_i         = 1'b0;
    bus.out_ready_i = 1'b1;
    push_exp(32'd42, 1'b0, 1'b0, 4'd12);
    push_exp(32'd45, 1'b0, 1'b1, 4'd13);
    neg();
    check("fl_after_valid",  64'(bus.out_valid_o),  64'd0);
    check("fl_after_rr",     64'(dbg_rr_ptr_o),     64'd0);
    check("fl_after_ready0", 64'(bus.req0_ready_o), 64'd1);
    check("fl_after_ready1", 64'(bus.req1_ready_o), 64'd0);
    nxt();
    idle(0);
    neg();
    check("fl_second_ready1", 64'(bus.req1_ready_o), 64'd1);
    nxt();
    idle(1);
    neg();

    // Async reset while a result is buffered.
    nxt();
    drive_req(0, 32'd1, 32'd2, mk_uop(OP_ADD, 32'd0), 4'd14);
    bus.out_ready_i = 1'b0;
    neg();
    check("rm_ready0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    idle(0);
    neg();
    check("rm_valid_before", 64'(bus.out_valid_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rm_valid", 64'(bus.out_valid_o), 64'd0);
    check("rm_res",   64'(bus.out_res_o),   64'd0);
    check("rm_tag",   64'(bus.out_tag_o),   64'd0);
    check("rm_rr",    64'(dbg_rr_ptr_o),    64'd0);
    nxt();
    nxt();
    rst_n_i         = 1'b1;
    bus.out_ready_i = 1'b1;

    // Traffic for the perf counters: 3 port-0, 2 port-1, 2 stalled cycles.
    nxt();
    drive_req(0, 32'd1, 32'd1, mk_uop(OP_ADD, 32'd0), 4'd1);
    push_exp(32'd2, 1'b0, 1'b0, 4'd1);
    nxt();
    idle(0);
    drive_req(1, 32'd5, 32'd1, mk_uop(OP_SUB, 32'd0), 4'd2);
    push_exp(32'd4, 1'b0, 1'b1, 4'd2);
    nxt();
    idle(1);
    drive_req(0, 32'd3, 32'd3, mk_uop(OP_ADD, 32'd0), 4'd3);
    push_exp(32'd6, 1'b0, 1'b0, 4'd3);
    nxt();
    idle(0);
    drive_req(1, 32'd9, 32'd2, mk_uop(OP_SUB, 32'd0), 4'd4);
    push_exp(32'd7, 1'b0, 1'b1, 4'd4);
    nxt();
    idle(1);
    drive_req(0, 32'd4, 32'd4, mk_uop(OP_ADD, 32'd0), 4'd5);
    push_exp(32'd8, 1'b0, 1'b0, 4'd5);
    bus.out_ready_i = 1'b0;
    neg();
    check("pf_stall0_ready0", 64'(bus.req0_ready_o), 64'd0);
    nxt();
    neg();
    check("pf_stall1_ready0", 64'(bus.req0_ready_o), 64'd0);
    nxt();
    bus.out_ready_i = 1'b1;
    neg();
    check("pf_release_ready0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    idle(0);
    neg();
    nxt();
    neg();
`ifdef ALU_ARB_PERF_EN
    check("perf_grant0", 64'(perf_grant0_o), 64'd3);
    check("perf_grant1", 64'(perf_grant1_o), 64'd2);
    check("perf_stall",  64'(perf_stall_o),  64'd2);
`endif

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle integer ALU between two requesters. Port 0 is the main EXU issue path; port 1 is an auxiliary path such as a branch/AGU helper.
- Arbitrates with round-robin priority, steers the winner's operands and uop into the ALU, and captures the ALU result and jump outputs into a one-entry output register with a valid/ready handshake.
- Sits between IDU/EXU issue and WBU/branch resolution.

Parameters:
- XLEN, 32, datapath width of operands and result.
- UOP_W, 96, packed width of uop_info_t carried to the ALU.
- TAG_W, 4, width of the opaque per-request tag returned with the result.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of buffered result and RR state
- req0_valid_i  in  1  requester 0 has an op
- req0_ready_o  out  1  requester 0 op accepted this cycle
- req0_rs1_i  in  XLEN  operand 1
- req0_rs2_i  in  XLEN  operand 2
- req0_uop_i  in  UOP_W  uop_info_t
- req0_tag_i  in  TAG_W  tag
- req1_valid_i, req1_ready_o, req1_rs1_i, req1_rs2_i, req1_uop_i, req1_tag_i: same as port 0, for requester 1
- alu_rs1_o  out  XLEN  to ALU rs1
- alu_rs2_o  out  XLEN  to ALU rs2
- alu_uop_o  out  UOP_W  to ALU uop_info
- alu_res_i  in  XLEN  ALU result (combinational)
- alu_jump_i  in  1  ALU branch outcome (combinational)
- out_valid_o  out  1  buffered result valid
- out_ready_i  in  1  consumer accepts result
- out_res_o  out  XLEN  result
- out_jump_o  out  1  jump flag
- out_src_o  out  1  winning requester id
- out_tag_o  out  TAG_W  tag of winning request

Behaviour:
- Reset values: out_valid_o=0, out_res_o=0, out_jump_o=0, out_src_o=0, out_tag_o=0, RR pointer=0 (port 0 preferred).
- Free signal: can_accept = ~out_valid_o | out_ready_i.
- Grant (combinational):
  - Only one valid: that port wins.
  - Both valid: port equal to RR pointer wins.
  - No grant when can_accept=0 or flush_i=1.
- reqN_ready_o = grant_N & can_accept & ~flush_i. A ready never depends on the same port's own ready.
- ALU steering: alu_* driven from the granted port. With no valid request, alu_* are driven from port 0 (don't-care, no X propagation).
- Handshake: a request transfers when valid & ready. On transfer in cycle N:
  - out register loads alu_res_i, alu_jump_i, src and tag at the rising edge ending N.
  - out_valid_o=1 in N+1. Latency 1 cycle; throughput 1 op/cycle.
- Out register hold: while out_valid_o & ~out_ready_i, all out_* hold stable and both readies are 0 (backpressure).
- Out register drain: out_ready_i with no new transfer clears out_valid_o; data fields hold their last value.
- Simultaneous pop and push: out_valid_o stays 1 and the new data loads, so there is no bubble.
- RR pointer: after a transfer when both were valid, pointer = ~winner. A single-valid transfer sets pointer = ~winner too, which guarantees alternation under contention.
- Request stability: requester must hold valid and payload until ready. The arbiter does not latch operands; a request withdrawn before ready is dropped silently.
- flush_i (takes precedence over everything):
  - Next cycle out_valid_o=0 and RR pointer=0.
  - No transfer in the flush cycle, so readies are 0.
- Async reset mid-transfer discards the in-flight op; all outputs return to reset values immediately.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- When defined, adds outputs perf_grant0_o, perf_grant1_o (32-bit saturating counts of transfers per port) and perf_stall_o (32-bit saturating count of cycles with any reqN_valid_i=1 but no transfer).
- Counters reset to 0 on rst_n_i; flush_i does not clear them.
- When not defined, these ports and all counter logic are absent.

Test Plan:
- Reset: hold rst_n_i=0 with random inputs -> out_valid_o=0, readies 0 after release until a request arrives; req0 ADDI rs1=5 imm=7 -> out_res_o=12, out_src_o=0 next cycle.
- Contention: both valid for 4 cycles, out_ready_i=1 -> grants 0,1,0,1; out_tag_o alternates port tags with no bubbles.
- Backpressure: out_ready_i=0 after first result -> out_* stable, readies 0 for 3 cycles; raise out_ready_i -> next op accepted same cycle, new result following cycle.
- Branch: req1 BEQ rs1=rs2=0x10 -> out_jump_o=1; BNE same operands -> out_jump_o=0.
- Flush: out_valid_o=1 with flush_i=1 and both valid -> no ready that cycle; out_valid_o=0 next cycle; next contention grants port 0 first.
- Perf (ALU_ARB_PERF_EN): 3 port-0 and 2 port-1 transfers plus 2 stalled cycles -> perf_grant0_o=3, perf_grant1_o=2, perf_stall_o=2.
